// File: rtl/alu_writeback_stage.sv
// Execute/write-back stage: single-cycle ALU ops plus an iterative shift-add
// multiplier, delivering each result as a one-cycle register-file write pulse.
module alu_writeback_stage #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [2:0]            opcode,
  input  logic [REG_WIDTH-1:0]  operand_a,
  input  logic [REG_WIDTH-1:0]  operand_b,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  output logic                  write_enabled,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [REG_WIDTH-1:0]  write_bus,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;
  localparam int CNT_W = $clog2(REG_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t state, state_next;

  logic [REG_WIDTH:0]       add_wide;
  logic [REG_WIDTH:0]       shl_wide;
  logic [31:0]              sh_amt;
  logic [REG_WIDTH-1:0]     alu_result;
  logic                     alu_carry;

  logic [2*REG_WIDTH-1:0]   mul_a;
  logic [REG_WIDTH-1:0]     mul_b;
  logic [2*REG_WIDTH-1:0]   mul_prod;
  logic [2*REG_WIDTH-1:0]   mul_next;
  logic [CNT_W-1:0]         mul_cnt;
  logic [ADDR_WIDTH-1:0]    dest_q;

  logic accept;
  logic mul_last;

  assign accept   = (state == IDLE) && issue_valid;
  assign mul_last = (mul_cnt == CNT_W'(1));

  assign add_wide = {1'b0, operand_a} + {1'b0, operand_b};
  assign sh_amt   = 32'(operand_b[3:0]);
  assign shl_wide = {1'b0, operand_a} << sh_amt;
  assign mul_next = mul_prod + (mul_b[0] ? mul_a : '0);

  // Single-cycle ALU; MUL is handled by the iterative datapath below.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_result = add_wide[REG_WIDTH-1:0];
        alu_carry  = add_wide[REG_WIDTH];
      end
      OP_SUB: begin
        alu_result = operand_a - operand_b;
        alu_carry  = (operand_a < operand_b);
      end
      OP_AND: alu_result = operand_a & operand_b;
      OP_OR:  alu_result = operand_a | operand_b;
      OP_XOR: alu_result = operand_a ^ operand_b;
      OP_SHL: begin
        if (sh_amt < REG_WIDTH) begin
          alu_result = shl_wide[REG_WIDTH-1:0];
          alu_carry  = (sh_amt != 0) && shl_wide[REG_WIDTH];
        end
      end
      OP_MOV: alu_result = operand_b;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue_valid) state_next = (opcode == OP_MUL) ? MUL : WB;
      MUL:  if (mul_last) state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue_ready   = (state == IDLE);
    write_enabled = (state == WB);
    busy          = (state != IDLE);
  end

  // Results and flags change only on the edge that enters WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_addr <= '0;
      write_bus  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_prod   <= '0;
      mul_cnt    <= '0;
      dest_q     <= '0;
    end else if (accept) begin
      dest_q <= dest_addr;
      if (opcode == OP_MUL) begin
        mul_a    <= {{REG_WIDTH{1'b0}}, operand_a};
        mul_b    <= operand_b;
        mul_prod <= '0;
        mul_cnt  <= CNT_W'(REG_WIDTH);
      end else begin
        write_addr <= dest_addr;
        write_bus  <= alu_result;
        flag_zero  <= (alu_result == '0);
        flag_carry <= alu_carry;
      end
    end else if (state == MUL) begin
      mul_prod <= mul_next;
      mul_a    <= mul_a << 1;
      mul_b    <= mul_b >> 1;
      mul_cnt  <= mul_cnt - CNT_W'(1);
      if (mul_last) begin
        write_addr <= dest_q;
        write_bus  <= mul_next[REG_WIDTH-1:0];
        flag_zero  <= (mul_next[REG_WIDTH-1:0] == '0);
        flag_carry <= |mul_next[2*REG_WIDTH-1:REG_WIDTH];
      end
    end
  end

endmodule
